// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Team 1-bit full-adder cell; the serial adder evaluates one bit through it per clock.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full-adder step per clock, valid/ready on both sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic               fa_sum, fa_cout, last_bit;
   logic [WIDTH-1:0]   sum_shift;

   full_adder u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Sum bits enter from the MSB side so that after WIDTH steps bit 0 sits at the LSB.
   if (WIDTH == 1) begin : g_shift_w1
      assign sum_shift = fa_sum;
   end else begin : g_shift_wn
      assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};
   end

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start_valid) state_d = ST_RUN;
         ST_RUN:  if (last_bit)    state_d = ST_DONE;
         ST_DONE: if (res_ready)   state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state_q == ST_IDLE);
      res_valid   = (state_q == ST_DONE);
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (state_q == ST_IDLE && start_valid) begin
         a_d     = a;
         b_d     = b;
         carry_d = cin;
         cnt_d   = '0;
      end else if (state_q == ST_RUN) begin
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         carry_d = fa_cout;
         sum_d   = sum_shift;
         cnt_d   = cnt_q + CNT_W'(1);
         // Overflow is the carry into the MSB cell XOR the carry out of it.
         if (last_bit) begin
            cout_d = fa_cout;
            ovf_d  = carry_q ^ fa_cout;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       s8_start_valid, s8_start_ready, s8_cin, s8_res_valid, s8_res_ready, s8_cout, s8_ovf;
   logic [7:0] s8_a, s8_b, s8_sum;
   logic       s1_start_valid, s1_start_ready, s1_cin, s1_res_valid, s1_res_ready, s1_cout, s1_ovf;
   logic [0:0] s1_a, s1_b, s1_sum;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(s8_start_valid), .start_ready(s8_start_ready),
      .a(s8_a), .b(s8_b), .cin(s8_cin),
      .res_valid(s8_res_valid), .res_ready(s8_res_ready),
      .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(s1_start_valid), .start_ready(s1_start_ready),
      .a(s1_a), .b(s1_b), .cin(s1_cin),
      .res_valid(s1_res_valid), .res_ready(s1_res_ready),
      .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: plain integer addition; signed overflow from operand/result sign bits.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input string tag, input bit retire);
      logic [8:0] full;
      logic [7:0] es;
      logic       ec, eo;
      int         lat;
      full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      es   = full[7:0];
      ec   = full[8];
      eo   = (a[7] == b[7]) && (es[7] != a[7]);
      @(negedge clk);
      check({tag, "_start_ready"}, 32'(s8_start_ready), 32'd1);
      s8_a = a; s8_b = b; s8_cin = ci; s8_start_valid = 1'b1;
      @(posedge clk); #1;
      s8_start_valid = 1'b0;
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom);
      lat = 0;
      while (s8_res_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
      check({tag, "_sum"},  32'(s8_sum),  32'(es));
      check({tag, "_cout"}, 32'(s8_cout), 32'(ec));
      check({tag, "_ovf"},  32'(s8_ovf),  32'(eo));
      if (retire) begin
         s8_res_ready = 1'b1;
         @(posedge clk); #1;
         s8_res_ready = 1'b0;
         check({tag, "_idle_ready"}, 32'({s8_start_ready, s8_res_valid}), 32'b10);
         check({tag, "_idle_hold"},  32'(s8_sum), 32'(es));
      end
   endtask

   task automatic op1(input logic a, input logic b, input logic ci, input string tag);
      logic [1:0] full;
      int         lat;
      full = {1'b0, a} + {1'b0, b} + {1'b0, ci};
      @(negedge clk);
      s1_a = a; s1_b = b; s1_cin = ci; s1_start_valid = 1'b1;
      @(posedge clk); #1;
      s1_start_valid = 1'b0;
      lat = 0;
      while (s1_res_valid !== 1'b1 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd1);
      check({tag, "_sum"},  32'(s1_sum),  32'(full[0]));
      check({tag, "_cout"}, 32'(s1_cout), 32'(full[1]));
      check({tag, "_ovf"},  32'(s1_ovf),  32'(ci ^ full[1]));
      s1_res_ready = 1'b1;
      @(posedge clk); #1;
      s1_res_ready = 1'b0;
      check({tag, "_idle_ready"}, 32'(s1_start_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] hs;
      logic       hc, ho;
      rst_n = 1'b0;
      s8_start_valid = 0; s8_res_ready = 0; s8_a = 0; s8_b = 0; s8_cin = 0;
      s1_start_valid = 0; s1_res_ready = 0; s1_a = 0; s1_b = 0; s1_cin = 0;
      #1;
      check("reset_outputs8", 32'({s8_sum, s8_cout, s8_ovf, s8_res_valid, s8_start_ready}), 32'h001);
      check("reset_outputs1", 32'({s1_sum, s1_cout, s1_ovf, s1_res_valid, s1_start_ready}), 32'h01);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;

      op8(8'h0F, 8'h01, 1'b0, "dir_0f_01", 1'b1);
      op8(8'hFF, 8'h00, 1'b1, "dir_ripple", 1'b1);
      op8(8'h7F, 8'h01, 1'b0, "dir_posovf", 1'b1);
      op8(8'h80, 8'h80, 1'b0, "dir_negovf", 1'b1);

      // Result held in DONE while start_valid toggles with fresh operands.
      op8(8'h35, 8'hC4, 1'b1, "hold", 1'b0);
      hs = s8_sum; hc = s8_cout; ho = s8_ovf;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s8_start_valid = ~s8_start_valid;
         s8_a = 8'($urandom); s8_b = 8'($urandom);
         @(posedge clk); #1;
         check("hold_outputs", 32'({s8_sum, s8_cout, s8_ovf}), 32'({hs, hc, ho}));
         check("hold_handshake", 32'({s8_start_ready, s8_res_valid}), 32'b01);
      end
      @(negedge clk);
      s8_start_valid = 1'b0; s8_res_ready = 1'b1;
      @(posedge clk); #1;
      s8_res_ready = 1'b0;
      check("hold_release", 32'({s8_start_ready, s8_res_valid}), 32'b10);

      // Asynchronous abort after bits 0..3 have been processed.
      @(negedge clk);
      s8_a = 8'hFF; s8_b = 8'hFF; s8_cin = 1'b1; s8_start_valid = 1'b1;
      @(posedge clk); #1;
      s8_start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_async", 32'({s8_sum, s8_cout, s8_ovf, s8_res_valid, s8_start_ready}), 32'h001);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_valid", 32'(s8_res_valid), 32'd0);
      end
      rst_n = 1'b1;
      op8(8'h5A, 8'h3C, 1'b1, "after_abort", 1'b1);

      for (int i = 0; i < 20; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8", 1'b1);

      for (int v = 0; v < 8; v++)
         op1(v[2], v[1], v[0], "w1_table");
      for (int i = 0; i < 6; i++)
         op1(1'($urandom), 1'($urandom), 1'($urandom), "rand1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_serial_adder
